// File: rtl/dlfloat_operand_loader.sv
// DLFloat16 operand loader: pairs incoming words into (A, B) operands, queues them
// in a small FIFO for the MAC, drives the pin output enable and flags NaN operands.
module dlfloat_operand_loader #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             data_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [W-1:0]             wa,
  output logic [W-1:0]             wb,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic                     write_en,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     nan_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // NaN has exponent and mantissa all ones; sign is don't-care.
  function automatic logic is_nan(input logic [W-1:0] v);
    return (v[W-2:0] == {(W-1){1'b1}});
  endfunction

  logic [2*W-1:0] r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_phase;
  logic [W-1:0]   r_a_hold;
  logic           r_nan;

  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic           w_nonempty;

  // Handshake qualifiers; in_ready never looks at op_ready.
  always_comb begin
    w_nonempty = (r_count != CW'(0));
    in_ready   = !rst && !flush && (r_count < CW'(DEPTH));
    w_accept   = in_valid && in_ready;
    w_push     = w_accept && r_phase;
    w_pop      = w_nonempty && op_ready && !flush && !rst;
  end

  // Pairing phase, FIFO storage, pointers, occupancy and sticky NaN flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
      r_phase  <= 1'b0;
      r_a_hold <= {W{1'b0}};
      r_nan    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {(2*W){1'b0}};
      end
    end else if (flush) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
      r_phase  <= 1'b0;
      r_nan    <= 1'b0;
    end else begin
      if (w_accept) begin
        if (!r_phase) begin
          r_a_hold <= data_in;
          r_phase  <= 1'b1;
        end else begin
          r_mem[r_wr_ptr] <= {r_a_hold, data_in};
          r_wr_ptr        <= r_wr_ptr + AW'(1);
          r_phase         <= 1'b0;
          if (is_nan(r_a_hold) || is_nan(data_in)) begin
            r_nan <= 1'b1;
          end
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head-of-queue presentation; empty queue reads as zero.
  always_comb begin
    op_valid = w_nonempty;
    write_en = w_nonempty;
    count    = r_count;
    nan_flag = r_nan;
    if (w_nonempty) begin
      wa = r_mem[r_rd_ptr][2*W-1:W];
      wb = r_mem[r_rd_ptr][W-1:0];
    end else begin
      wa = {W{1'b0}};
      wb = {W{1'b0}};
    end
  end

endmodule
